pwm_clkgen: RTL and testbench

PWM_CLKGEN -- requirements
Module: pwm_clkgen

---
 rtl/pwm_clkgen_pkg.sv | 16 +
 rtl/pwm_clkgen_ch.sv | 78 +++++++
 rtl/pwm_clkgen.sv | 51 +++++
 tb/tb_pwm_clkgen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_clkgen_pkg.sv
// Shared reset defaults and channel configuration type for the PWM clock generator.
// Config fields are sized for the widest supported counter; channels use the low CNT_W bits.
package pwm_clkgen_pkg;

    localparam int CFG_W      = 16;
    localparam int RST_PERIOD = 1;
    localparam int RST_HIGH   = 1;

    typedef struct packed {
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] high;
    } ch_cfg_t;

    localparam ch_cfg_t RST_CFG = '{period: CFG_W'(RST_PERIOD), high: CFG_W'(RST_HIGH)};

endpackage

// File: rtl/pwm_clkgen_ch.sv
// One PWM channel: period counter, shadow/active config, registered clk_out/tick (1 cycle from en).
// Holds at most one pending write; the top deasserts ready while it waits for the period wrap.
module pwm_clkgen_ch
    import pwm_clkgen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    en_i,
    input  logic    wr_i,
    input  ch_cfg_t wr_cfg_i,
    output logic    pending_o,
    output logic    clk_out_o,
    output logic    tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    ch_cfg_t          act_q, act_d;
    ch_cfg_t          shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic [CFG_W-1:0] cnt_ext;
    logic             wrap;
    logic             apply;

    assign cnt_ext = CFG_W'(cnt_q);
    assign wrap    = (cnt_ext == act_q.period);
    // Swapping only at the wrap (or while idle) keeps every running period whole.
    assign apply   = pend_q && (!en_i || wrap);

    always_comb begin
        cnt_d     = '0;
        act_d     = act_q;
        shd_d     = shd_q;
        pend_d    = pend_q;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        if (en_i) begin
            clk_out_d = (cnt_ext < act_q.high);
            tick_d    = (cnt_q == '0);
            cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        end
        if (apply) begin
            act_d  = shd_q;
            pend_d = 1'b0;
        end
        if (wr_i) begin
            shd_d  = wr_cfg_i;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            act_q     <= RST_CFG;
            shd_q     <= RST_CFG;
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            shd_q     <= shd_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign pending_o = pend_q;
    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/pwm_clkgen.sv
// Multi-channel PWM/clock generator top: config write decode and per-channel ready mux.
// Outputs 1 cycle after en; cfg_ready is low while the addressed channel holds an unapplied write.
module pwm_clkgen
    import pwm_clkgen_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] pending;
    logic              ch_ok;
    logic              wr_vld;
    ch_cfg_t           wr_cfg;

    // Out-of-range channels always look ready so their writes drain and are dropped.
    assign ch_ok     = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
    assign cfg_ready = ch_ok ? !pending[cfg_ch] : 1'b1;
    assign wr_vld    = cfg_valid && cfg_ready && ch_ok;

    always_comb begin
        wr_cfg        = '0;
        wr_cfg.period = CFG_W'(cfg_period);
        wr_cfg.high   = CFG_W'(cfg_high);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_clkgen_ch #(.CNT_W(CNT_W)) u_ch (
            .clk_i     (clk),
            .rst_i     (rst),
            .en_i      (en[i]),
            .wr_i      (wr_vld && (cfg_ch == CH_W'(i))),
            .wr_cfg_i  (wr_cfg),
            .pending_o (pending[i]),
            .clk_out_o (clk_out[i]),
            .tick_o    (tick[i])
        );
    end

endmodule

// File: tb/tb_pwm_clkgen.sv
// Directed and randomized checks of pwm_clkgen against a cycle-level arithmetic model.
// A second 5-channel instance exercises writes to an out-of-range channel index.
module tb_pwm_clkgen;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_period;
    logic [7:0] cfg_high;
    logic [3:0] clk_out;
    logic [3:0] tick;

    logic [4:0] en5;
    logic       cfg_valid5;
    logic       cfg_ready5;
    logic [2:0] cfg_ch5;
    logic [7:0] cfg_period5;
    logic [7:0] cfg_high5;
    logic [4:0] clk_out5;
    logic [4:0] tick5;

    pwm_clkgen #(.NUM_CH(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_high(cfg_high),
        .clk_out(clk_out), .tick(tick)
    );

    pwm_clkgen #(.NUM_CH(5), .CNT_W(8)) u_dut5 (
        .clk(clk), .rst(rst), .en(en5), .cfg_valid(cfg_valid5), .cfg_ready(cfg_ready5),
        .cfg_ch(cfg_ch5), .cfg_period(cfg_period5), .cfg_high(cfg_high5),
        .clk_out(clk_out5), .tick(tick5)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: position within the period plus active/shadow settings, as plain integers.
    int         m_per[4], m_high[4], m_sper[4], m_shigh[4], m_pos[4];
    bit         m_pend[4];
    logic [3:0] m_clk, m_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  wch;
        bit  acc;
        wch = int'(cfg_ch);
        acc = cfg_valid && !m_pend[wch];
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_per[i] = 1; m_high[i] = 1; m_sper[i] = 1; m_shigh[i] = 1;
                m_pos[i] = 0; m_pend[i] = 0;
            end
            m_clk  = '0;
            m_tick = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (en[i]) begin
                    m_clk[i]  = (m_pos[i] < m_high[i]);
                    m_tick[i] = (m_pos[i] == 0);
                    m_pos[i]  = (m_pos[i] + 1) % (m_per[i] + 1);
                end else begin
                    m_clk[i]  = 1'b0;
                    m_tick[i] = 1'b0;
                    m_pos[i]  = 0;
                end
                if (m_pend[i] && m_pos[i] == 0) begin
                    m_per[i]  = m_sper[i];
                    m_high[i] = m_shigh[i];
                    m_pend[i] = 0;
                end
                if (acc && wch == i) begin
                    m_sper[i]  = int'(cfg_period);
                    m_shigh[i] = int'(cfg_high);
                    m_pend[i]  = 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        if (!rst) cyc++;
        #1;
        chk("clk_out", clk_out, m_clk);
        chk("tick", tick, m_tick);
        chk("cfg_ready", cfg_ready, !m_pend[int'(cfg_ch)]);
    endtask

    task automatic wr(input int ch, input int p, input int h);
        cfg_valid  = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = 8'(p);
        cfg_high   = 8'(h);
        step();
        cfg_valid  = 1'b0;
    endtask

    task automatic run_count(input int c, input int n, output int hi, output int tk);
        hi = 0;
        tk = 0;
        repeat (n) begin
            step();
            hi += int'(clk_out[c]);
            tk += int'(tick[c]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hi, tk, n;
        bit got;
        logic [3:0] pat, tpat;

        rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0;
        en5 = '0; cfg_valid5 = 1'b0; cfg_ch5 = '0; cfg_period5 = '0; cfg_high5 = '0;
        step(); step();
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_ready", cfg_ready, 1);

        // Reset wins over enable and config traffic.
        en = 4'hF; cfg_valid = 1'b1;
        step();
        chk("rst_prio", clk_out, 0);
        cfg_valid = 1'b0;

        rst = 1'b0; en = 4'b0001; en5 = 5'h1F;
        pat = '0; tpat = '0;
        repeat (4) begin
            step();
            pat  = {pat[2:0], clk_out[0]};
            tpat = {tpat[2:0], tick[0]};
        end
        chk("ch0_toggle", pat, 4'b1010);
        chk("ch0_tick", tpat, 4'b1010);

        // 70% duty on ch1, configured while idle.
        wr(1, 9, 7);
        step();
        en[1] = 1'b1;
        run_count(1, 20, hi, tk);
        chk("duty70_high", hi, 14);
        chk("duty70_tick", tk, 2);

        // Mid-period update: old period finishes before the new one starts.
        step(); step(); step();
        wr(1, 4, 2);
        chk("ready_low", cfg_ready, 0);
        n = 0;
        while (!cfg_ready && n < 40) begin
            step();
            n++;
        end
        chk("wrap_wait", n, 6);
        run_count(1, 10, hi, tk);
        chk("upd_high", hi, 4);
        chk("upd_tick", tk, 2);

        // Disable at cnt = 4, then restart from a fresh period.
        step(); step(); step(); step();
        en[1] = 1'b0;
        step();
        chk("dis_clk", clk_out[1], 0);
        step();
        chk("dis_tick", tick[1], 0);
        en[1] = 1'b1;
        step();
        chk("reen_tick", tick[1], 1);
        chk("reen_clk", clk_out[1], 1);
        run_count(1, 4, hi, tk);
        chk("reen_high", hi, 1);
        chk("reen_tick_rest", tk, 0);

        // Extremes on ch2.
        wr(2, 3, 0);
        step();
        en[2] = 1'b1;
        run_count(2, 8, hi, tk);
        chk("h0_high", hi, 0);
        chk("h0_tick", tk, 2);
        en[2] = 1'b0;
        wr(2, 9, 12);
        step();
        en[2] = 1'b1;
        run_count(2, 10, hi, tk);
        chk("hbig_high", hi, 10);
        chk("hbig_tick", tk, 1);
        en[2] = 1'b0;
        wr(2, 0, 1);
        step();
        en[2] = 1'b1;
        run_count(2, 6, hi, tk);
        chk("p0_tick", tk, 6);
        chk("p0_high", hi, 6);
        en[2] = 1'b0;

        // 256-cycle period on ch3.
        wr(3, 255, 100);
        step();
        en[3] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 600 && !got; k++) begin
            step();
            if (tick[3]) got = 1'b1;
        end
        chk("p255_first_tick", got, 1);
        n = 0; hi = 0;
        do begin
            step();
            n++;
            hi += int'(clk_out[3]);
        end while (!tick[3] && n < 600);
        chk("p255_len", n, 256);
        chk("p255_high", hi, 100);

        // Independent configs on all four channels.
        en = '0;
        wr(0, 3, 1);
        wr(1, 5, 4);
        wr(2, 6, 0);
        wr(3, 2, 3);
        step();
        en = 4'hF;
        repeat (20) step();
        wr(2, 4, 3);
        run_count(0, 12, hi, tk);
        chk("iso_ch0_high", hi, 3);
        chk("iso_ch0_tick", tk, 3);

        // Out-of-range write on the 5-channel instance is accepted and dropped.
        cfg_valid5 = 1'b1; cfg_ch5 = 3'd5; cfg_period5 = 8'd9; cfg_high5 = 8'd0;
        #1;
        chk("oob_ready", cfg_ready5, 1);
        step();
        cfg_valid5 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cfg_ch5 = 3'(k);
            #1;
            chk("oob_no_pending", cfg_ready5, 1);
        end
        repeat (12) begin
            step();
            chk("oob_clk5", clk_out5, (cyc % 2 == 1) ? 5'h1F : 5'h00);
            chk("oob_tick5", tick5, (cyc % 2 == 1) ? 5'h1F : 5'h00);
        end

        // Randomized traffic, with one reset pulse in the middle.
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 15) == 0) en[$urandom_range(0, 3)] ^= 1'b1;
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_period = 8'($urandom_range(0, 12));
            cfg_high   = 8'($urandom_range(0, 14));
            rst        = (k == 250);
            step();
        end
        rst = 1'b0;
        cfg_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
